// File: rtl/jump_resolve_unit_pkg.sv
// Shared definitions for the jump resolve unit.
//  - JUMP_OP_* : 4-bit branch-condition encodings carried on ex_op
//  - bht_state_t : 2-bit saturating predictor counter states
//  - BHT_RST : reset value of every predictor entry (weakly not-taken)
//  - idx_width() : predictor index width for a given table depth
//  - is_branch() : true for ops that train the predictor and can mispredict
package jump_resolve_unit_pkg;

    localparam logic [3:0] JUMP_OP_NOP   = 4'd0;
    localparam logic [3:0] JUMP_OP_EN    = 4'd1;
    localparam logic [3:0] JUMP_OP_ZERO  = 4'd2;
    localparam logic [3:0] JUMP_OP_NZERO = 4'd3;
    localparam logic [3:0] JUMP_OP_LTZ   = 4'd4;
    localparam logic [3:0] JUMP_OP_GEZ   = 4'd5;
    localparam logic [3:0] JUMP_OP_GTZ   = 4'd6;
    localparam logic [3:0] JUMP_OP_LEZ   = 4'd7;
    localparam logic [3:0] JUMP_OP_EQ    = 4'd8;
    localparam logic [3:0] JUMP_OP_NE    = 4'd9;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RST = BHT_WNT;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // NOP and EN are not conditional branches; everything else, including
    // undefined encodings, is treated as branch-class.
    function automatic logic is_branch(input logic [3:0] op);
        return !((op == JUMP_OP_NOP) || (op == JUMP_OP_EN));
    endfunction

endpackage

// File: rtl/jump_resolve_unit_if.sv
// Bundles the fetch prediction port and the EX-stage resolve port.
//  master : pipeline side (drives fetch PC and EX instruction fields)
//  slave  : jump_resolve_unit (returns prediction, outcome, redirect, stats)
interface jump_resolve_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic [3:0]       ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic             ex_pred_taken;
    logic             jump_en;
    logic             mispredict;
    logic             redirect_tkn;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_op, ex_a, ex_b, ex_pred_taken,
        input  if_pred_taken, jump_en, mispredict, redirect_tkn, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_op, ex_a, ex_b, ex_pred_taken,
        output if_pred_taken, jump_en, mispredict, redirect_tkn, mispred_cnt
    );
endinterface

// File: rtl/jump_cond_eval.sv
// Combinational branch-condition evaluator.
//  op   : JUMP_OP_* encoding
//  a, b : WIDTH-bit operands (a is two's complement for sign tests)
//  cond : condition result; undefined encodings give 0
module jump_cond_eval
    import jump_resolve_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cond
);

    logic a_zero;
    logic a_neg;

    assign a_zero = (a == '0);
    assign a_neg  = a[WIDTH-1];

    always_comb begin
        cond = 1'b0;
        case (op)
            JUMP_OP_NOP:   cond = 1'b0;
            JUMP_OP_EN:    cond = 1'b1;
            JUMP_OP_ZERO:  cond = a_zero;
            JUMP_OP_NZERO: cond = !a_zero;
            JUMP_OP_LTZ:   cond = a_neg;
            JUMP_OP_GEZ:   cond = !a_neg;
            JUMP_OP_GTZ:   cond = !a_neg && !a_zero;
            JUMP_OP_LEZ:   cond = a_neg || a_zero;
            JUMP_OP_EQ:    cond = (a == b);
            JUMP_OP_NE:    cond = (a != b);
            default:       cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/jump_resolve_unit.sv
// Jump resolve unit: resolves EX-stage branch conditions, predicts at fetch
// from a table of 2-bit saturating counters, trains the table at EX, and
// flags mispredicts one cycle after resolution.
//  clk, rst : rising-edge clock, asynchronous active-high reset
//  bus      : slave side of jump_resolve_unit_if (fetch + EX ports)
module jump_resolve_unit
    import jump_resolve_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    jump_resolve_unit_if.slave bus
);

    localparam int IDX_W = idx_width(BHT_DEPTH);

    logic             cond;
    logic             jump_en;
    logic             train;
    logic             mis_d;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       if_entry;
    bht_state_t       bht [BHT_DEPTH];
    bht_state_t       bht_next;
    logic             mispredict_q;
    logic             redirect_q;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_pc_bits;

    jump_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .op   (bus.ex_op),
        .a    (bus.ex_a),
        .b    (bus.ex_b),
        .cond (cond)
    );

    assign jump_en = bus.ex_valid & cond;
    assign train   = bus.ex_valid & is_branch(bus.ex_op);
    assign mis_d   = train & (jump_en != bus.ex_pred_taken);

    // Word-aligned PCs: bits [1:0] never select an entry.
    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];

    assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                              bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

    // Prediction reads the stored table only, so a same-cycle update to the
    // same entry shows up on the following cycle.
    assign if_entry          = bht[if_idx];
    assign bus.if_pred_taken = if_entry[1];

    // Counter step for the entry being trained this cycle.
    always_comb begin
        bht_next = bht[ex_idx];
        case (bht[ex_idx])
            BHT_SNT: bht_next = jump_en ? BHT_WNT : BHT_SNT;
            BHT_WNT: bht_next = jump_en ? BHT_WT  : BHT_SNT;
            BHT_WT:  bht_next = jump_en ? BHT_ST  : BHT_WNT;
            BHT_ST:  bht_next = jump_en ? BHT_ST  : BHT_WT;
            default: bht_next = BHT_RST;
        endcase
    end

    // Flop-based table so every entry takes the async reset value together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_RST;
            end
        end else if (train) begin
            bht[ex_idx] <= bht_next;
        end
    end

    // Mispredict/redirect are registered for the PC mux; the statistics
    // counter advances on the same edge the mispredict flag is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_q <= 1'b0;
            redirect_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            mispredict_q <= mis_d;
            redirect_q   <= mis_d & jump_en;
            if (mis_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.jump_en      = jump_en;
    assign bus.mispredict   = mispredict_q;
    assign bus.redirect_tkn = redirect_q;
    assign bus.mispred_cnt  = cnt_q;

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Self-checking bench for jump_resolve_unit: a table of directed condition
// vectors plus hand-written predictor, reset and saturation sequences.
// A second instance with CNT_W=2 mirrors the stimulus for counter saturation.
module tb_jump_resolve_unit;
    import jump_resolve_unit_pkg::*;

    logic clk;
    logic rst;

    jump_resolve_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();
    jump_resolve_unit_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

    jump_resolve_unit #(.WIDTH(32), .BHT_DEPTH(64), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    jump_resolve_unit #(.WIDTH(32), .BHT_DEPTH(64), .CNT_W(2)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    assign bus2.if_pc         = bus.if_pc;
    assign bus2.ex_valid      = bus.ex_valid;
    assign bus2.ex_pc         = bus.ex_pc;
    assign bus2.ex_op         = bus.ex_op;
    assign bus2.ex_a          = bus.ex_a;
    assign bus2.ex_b          = bus.ex_b;
    assign bus2.ex_pred_taken = bus.ex_pred_taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        valid;
        logic        pred;
        logic        exp_j;
        logic        exp_m;
        logic        exp_r;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = '0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic valid,
                                input logic pred, input logic j,
                                input logic m, input logic r);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.valid = valid; v.pred = pred;
        v.exp_j = j; v.exp_m = m; v.exp_r = r;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input logic [31:0] pc);
        bus.ex_op         = v.op;
        bus.ex_a          = v.a;
        bus.ex_b          = v.b;
        bus.ex_valid      = v.valid;
        bus.ex_pred_taken = v.pred;
        bus.ex_pc         = pc;
    endtask

    // Called at posedge+1 (+ up to 2 more units); checks the combinational
    // outcome before the edge and the registered outputs just after it.
    task automatic settle_and_check(input vec_t v, input string tag);
        #3;
        check_output({tag, " jump_en"}, {31'd0, bus.jump_en}, {31'd0, v.exp_j});
        @(posedge clk);
        #1;
        if (v.exp_m) exp_cnt = exp_cnt + 16'd1;
        check_output({tag, " mispredict"}, {31'd0, bus.mispredict}, {31'd0, v.exp_m});
        check_output({tag, " redirect_tkn"}, {31'd0, bus.redirect_tkn}, {31'd0, v.exp_r});
        check_output({tag, " mispred_cnt"}, {16'd0, bus.mispred_cnt}, {16'd0, exp_cnt});
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] pc, input string tag);
        apply_stimulus(v, pc);
        settle_and_check(v, tag);
    endtask

    vec_t vecs [20];
    vec_t beq_tk, beq_nt, eq_idle, c_nt, c_tk, z_mis;

    initial begin
        vecs[0]  = mk(JUMP_OP_ZERO,  32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[1]  = mk(JUMP_OP_ZERO,  32'h0000_0001, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(JUMP_OP_NZERO, 32'h0000_0007, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[3]  = mk(JUMP_OP_LTZ,   32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(JUMP_OP_GEZ,   32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(JUMP_OP_GTZ,   32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(JUMP_OP_LEZ,   32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[7]  = mk(JUMP_OP_GTZ,   32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(JUMP_OP_LEZ,   32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(JUMP_OP_GEZ,   32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[10] = mk(JUMP_OP_GTZ,   32'h0000_0005, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(JUMP_OP_LTZ,   32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[12] = mk(JUMP_OP_EQ,    32'h0000_0005, 32'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(JUMP_OP_NE,    32'h0000_0005, 32'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(JUMP_OP_NE,    32'h0000_0001, 32'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[15] = mk(JUMP_OP_EN,    32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(JUMP_OP_NOP,   32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(4'hF,          32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(JUMP_OP_ZERO,  32'h0000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(JUMP_OP_LEZ,   32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        beq_tk  = mk(JUMP_OP_EQ,   32'h5, 32'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        beq_nt  = mk(JUMP_OP_EQ,   32'h5, 32'h6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        eq_idle = mk(JUMP_OP_EQ,   32'h5, 32'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        c_nt    = mk(JUMP_OP_EQ,   32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        c_tk    = mk(JUMP_OP_EQ,   32'h3, 32'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        z_mis   = mk(JUMP_OP_ZERO, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset and idle state.
        rst = 1'b1;
        bus.if_pc = 32'h40;
        apply_stimulus(mk(JUMP_OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset if_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
        check_output("reset jump_en", {31'd0, bus.jump_en}, 32'd0);
        check_output("reset mispredict", {31'd0, bus.mispredict}, 32'd0);
        check_output("reset redirect_tkn", {31'd0, bus.redirect_tkn}, 32'd0);
        check_output("reset mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd0);
        check_output("reset small cnt", {30'd0, bus2.mispred_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Condition table at an index the predictor sequences never use.
        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i], 32'h300, $sformatf("vec%0d", i));
        end

        // Taken BEQ training, same-cycle read shows the old entry.
        bus.if_pc = 32'h80;
        apply_stimulus(beq_tk, 32'h80);
        #2;
        check_output("bht same-cycle old", {31'd0, bus.if_pred_taken}, 32'd0);
        settle_and_check(beq_tk, "beq1");
        check_output("bht 01->10", {31'd0, bus.if_pred_taken}, 32'd1);
        run_vec(beq_tk, 32'h80, "beq2");
        check_output("bht 10->11", {31'd0, bus.if_pred_taken}, 32'd1);
        run_vec(beq_tk, 32'h80, "beq3");
        check_output("bht 11 sat", {31'd0, bus.if_pred_taken}, 32'd1);
        run_vec(beq_nt, 32'h80, "bnt1");
        check_output("bht 11->10", {31'd0, bus.if_pred_taken}, 32'd1);
        run_vec(beq_nt, 32'h80, "bnt2");
        check_output("bht 10->01", {31'd0, bus.if_pred_taken}, 32'd0);
        run_vec(eq_idle, 32'h80, "idle1");
        run_vec(eq_idle, 32'h80, "idle2");
        check_output("bht invalid no train", {31'd0, bus.if_pred_taken}, 32'd0);

        // Saturation at strongly not-taken.
        bus.if_pc = 32'hC0;
        run_vec(c_nt, 32'hC0, "cnt1");
        run_vec(c_nt, 32'hC0, "cnt2");
        check_output("bht 00 sat", {31'd0, bus.if_pred_taken}, 32'd0);
        run_vec(c_tk, 32'hC0, "ctk1");
        check_output("bht 00->01", {31'd0, bus.if_pred_taken}, 32'd0);
        run_vec(c_tk, 32'hC0, "ctk2");
        check_output("bht 01->10 c0", {31'd0, bus.if_pred_taken}, 32'd1);

        // Async reset while a mispredict is showing and training is in flight.
        run_vec(z_mis, 32'h300, "premis");
        apply_stimulus(c_tk, 32'hC0);
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = '0;
        check_output("async rst mispredict", {31'd0, bus.mispredict}, 32'd0);
        check_output("async rst redirect", {31'd0, bus.redirect_tkn}, 32'd0);
        check_output("async rst cnt", {16'd0, bus.mispred_cnt}, 32'd0);
        check_output("async rst table", {31'd0, bus.if_pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        check_output("rst held no train", {31'd0, bus.if_pred_taken}, 32'd0);
        bus.ex_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(c_tk, 32'hC0, "post rst tk");
        check_output("post rst 01->10", {31'd0, bus.if_pred_taken}, 32'd1);

        // Statistics counter saturation on the CNT_W=2 instance.
        for (int i = 0; i < 5; i++) begin
            run_vec(z_mis, 32'h300, $sformatf("sat%0d", i));
        end
        check_output("small cnt sat", {30'd0, bus2.mispred_cnt}, 32'd3);

        bus.ex_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
